// File: rtl/oc8051_fetch_buffer.sv
// oc8051_fetch_buffer: instruction prefetch buffer between the code ROM and the
// 8051 decoder. Fetches 32-bit words from the ROM into a byte FIFO and presents
// the three bytes at the decoder PC. The decoder retires 0..3 bytes per cycle.
// A jump flushes the FIFO and restarts fetching at the new address.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cxrom_req/addr    fetch strobe and byte address (always the fetch address)
//   cxrom_data_in     ROM word {b3,b2,b1,b0}, b0 at cxrom_addr, same cycle
//   op_valid          op1..op3 / pc_out valid
//   op1, op2, op3     bytes at pc_out, pc_out+1, pc_out+2 (zero when invalid)
//   pc_out            decoder architectural PC
//   consume           bytes retired this cycle, honoured when op_valid
//   jmp, jmp_addr     redirect to jmp_addr
module oc8051_fetch_buffer #(
  parameter int unsigned BUF_BYTES = 8,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cxrom_req,
  output logic [15:0] cxrom_addr,
  input  logic [31:0] cxrom_data_in,
  output logic        op_valid,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [7:0]  op3,
  output logic [15:0] pc_out,
  input  logic [1:0]  consume,
  input  logic        jmp,
  input  logic [15:0] jmp_addr
);

  localparam int unsigned PTR_W = $clog2(BUF_BYTES);
  localparam int unsigned CNT_W = $clog2(BUF_BYTES + 1);

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e             state_q;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        fa_q, fa_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [7:0]         mem_q [BUF_BYTES];
  logic [1:0]         consume_eff;

  // Fetch only while a whole word still fits; never in the flush cycle or on a jump.
  assign cxrom_req  = (state_q != S_FLUSH) && !jmp &&
                      (cnt_q <= CNT_W'(BUF_BYTES - 4));
  assign cxrom_addr = fa_q;
  assign op_valid   = (state_q == S_RUN) && (cnt_q >= CNT_W'(3)) && !jmp;
  assign pc_out     = pc_q;

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  assign op1 = op_valid ? mem_q[head_q]                : 8'h00;
  assign op2 = op_valid ? mem_q[head_q + PTR_W'(1)]    : 8'h00;
  assign op3 = op_valid ? mem_q[head_q + PTR_W'(2)]    : 8'h00;

  // Next-state datapath for a normal (no reset, no jump) cycle.
  always_comb begin
    consume_eff = 2'd0;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pc_d        = pc_q;
    fa_d        = fa_q;
    if (op_valid) begin
      consume_eff = consume;
    end
    cnt_d  = cnt_q + (cxrom_req ? CNT_W'(4) : CNT_W'(0)) - CNT_W'(consume_eff);
    head_d = head_q + PTR_W'(consume_eff);
    tail_d = tail_q + (cxrom_req ? PTR_W'(4) : PTR_W'(0));
    pc_d   = pc_q + 16'(consume_eff);
    fa_d   = fa_q + (cxrom_req ? 16'd4 : 16'd0);
  end

  // Control state, pointers and FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FLUSH;
      pc_q    <= RESET_PC;
      fa_q    <= RESET_PC;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (jmp) begin
      state_q <= S_FLUSH;
      pc_q    <= jmp_addr;
      fa_q    <= jmp_addr;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      fa_q   <= fa_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      case (state_q)
        S_FLUSH: state_q <= S_FILL;
        S_FILL:  if (cnt_d >= CNT_W'(3)) state_q <= S_RUN;
        S_RUN:   if (cnt_d <  CNT_W'(3)) state_q <= S_FILL;
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  // Byte storage; contents need no reset since cnt gates every read.
  always_ff @(posedge clk) begin
    if (!rst && cxrom_req) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[tail_q + PTR_W'(i)] <= cxrom_data_in[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_oc8051_fetch_buffer.sv
// Testbench for oc8051_fetch_buffer: directed scenarios followed by random
// consume/jump/reset traffic, checked against a byte-queue reference model
// through a scoreboard queue.
module tb_oc8051_fetch_buffer;

  localparam int unsigned BUF_BYTES = 8;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  logic        clk;
  logic        rst;
  logic        cxrom_req;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        op_valid;
  logic [7:0]  op1, op2, op3;
  logic [15:0] pc_out;
  logic [1:0]  consume;
  logic        jmp;
  logic [15:0] jmp_addr;

  oc8051_fetch_buffer #(.BUF_BYTES(BUF_BYTES), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .cxrom_req(cxrom_req), .cxrom_addr(cxrom_addr), .cxrom_data_in(cxrom_data_in),
    .op_valid(op_valid), .op1(op1), .op2(op2), .op3(op3), .pc_out(pc_out),
    .consume(consume), .jmp(jmp), .jmp_addr(jmp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    if (a == 16'h0000) return 8'h15;
    if (a == 16'h0001) return 8'hA8;
    return 8'h00;
  endfunction

  always_comb begin
    cxrom_data_in = {rom(cxrom_addr + 16'd3), rom(cxrom_addr + 16'd2),
                     rom(cxrom_addr + 16'd1), rom(cxrom_addr)};
  end

  typedef struct packed {
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [7:0]  o1, o2, o3;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: bytes waiting for the decoder, PC, fetch address, flush flag.
  logic [7:0]  mq[$];
  logic [15:0] mpc, mfa;
  bit          mflush;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive inputs, predict outputs, advance the model across the edge.
  task automatic step(input bit r, input bit j, input logic [15:0] ja, input logic [1:0] c);
    exp_t e;
    rst = r; jmp = j; jmp_addr = ja; consume = c;
    e.req   = !mflush && !j && (mq.size() <= BUF_BYTES - 4);
    e.addr  = mfa;
    e.valid = !mflush && !j && (mq.size() >= 3);
    e.o1    = e.valid ? mq[0] : 8'h00;
    e.o2    = e.valid ? mq[1] : 8'h00;
    e.o3    = e.valid ? mq[2] : 8'h00;
    e.pc    = mpc;
    sb.push_back(e);
    if (r) begin
      mq.delete(); mpc = RESET_PC; mfa = RESET_PC; mflush = 1'b1;
    end else if (j) begin
      mq.delete(); mpc = ja; mfa = ja; mflush = 1'b1;
    end else begin
      mflush = 1'b0;
      if (e.valid) begin
        for (int k = 0; k < int'(c); k++) void'(mq.pop_front());
        mpc = mpc + 16'(c);
      end
      if (e.req) begin
        for (int k = 0; k < 4; k++) mq.push_back(rom(mfa + 16'(k)));
        mfa = mfa + 16'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the presented outputs with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cxrom_req", 64'(cxrom_req), 64'(e.req));
      if (e.req) check("cxrom_addr", 64'(cxrom_addr), 64'(e.addr));
      check("op_valid", 64'(op_valid), 64'(e.valid));
      check("op_window", 64'({op1, op2, op3, pc_out}), 64'({e.o1, e.o2, e.o3, e.pc}));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 2'd0);
  endtask

  initial begin
    logic [15:0] ja;
    rst = 1'b1; jmp = 1'b0; jmp_addr = '0; consume = '0;
    mq.delete(); mpc = RESET_PC; mfa = RESET_PC; mflush = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 16'h0000, 2'd0);

    // Startup, then consume 2 in the first valid cycle.
    step(1'b0, 1'b0, 16'h0000, 2'd0);
    step(1'b0, 1'b0, 16'h0000, 2'd0);
    step(1'b0, 1'b0, 16'h0000, 2'd2);
    idle(4);

    // Fresh start with consume held at 0: buffer fills and fetching stops.
    step(1'b1, 1'b0, 16'h0000, 2'd0);
    idle(8);

    // Jump near the top of the address space.
    step(1'b0, 1'b1, 16'hFFFE, 2'd0);
    idle(5);
    step(1'b0, 1'b0, 16'h0000, 2'd1);
    step(1'b0, 1'b0, 16'h0000, 2'd1);
    idle(2);

    // Jump together with a full consume.
    step(1'b0, 1'b1, 16'h0001, 2'd3);
    idle(4);
    step(1'b0, 1'b0, 16'h0000, 2'd3);
    idle(3);

    // Reset while running with a full buffer, then restart.
    idle(4);
    step(1'b1, 1'b1, 16'h1234, 2'd3);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       ja = 16'($urandom);
        default: ja = 16'hFFF8 + 16'($urandom_range(0, 11));
      endcase
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0), ja,
           2'($urandom_range(0, 3)));
    end
    idle(2);

    @(negedge clk);
    @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
